// File: rtl/instr_encoder.sv
// Instruction encoder: packs {op, operand} beats into machine words and writes
// them to instruction memory starting at base_addr, two cycles per word
// (capture beat, then write). A shift by more than 7 stops the load before it
// is written. A non-final word written at the top address also stops the load,
// after that word has been written.
module instr_encoder #(
  parameter int AW = 10,
  parameter int IW = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [4:0]    in_operand,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [IW-1:0] mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW:0]   word_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_SHIFT = 2'b01;
  localparam logic [1:0] E_OVF   = 2'b10;

  logic [2:0]    state;
  logic [AW-1:0] addr_r;
  logic          last_r;
  logic          ovf_r;

  logic shift_bad;
  logic at_top;

  // lsl/rsl can only shift by 0..7; larger amounts abort the load
  assign shift_bad = ((in_op == 4'b1101) || (in_op == 4'b1111)) && (in_operand > 5'd7);
  assign at_top    = (addr_r == {AW{1'b1}});

  // Status and strobes are decoded from state only, so an async reset drops
  // mem_we in the same cycle it is asserted
  assign in_ready = (state == S_ACCEPT);
  assign mem_we   = (state == S_WRITE);
  assign busy     = (state == S_ACCEPT) || (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERROR);

  // Load sequencer: capture beat in ACCEPT, commit address/count in WRITE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      addr_r     <= '0;
      last_r     <= 1'b0;
      ovf_r      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err_code   <= E_NONE;
      word_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state      <= S_ACCEPT;
            addr_r     <= base_addr;
            word_count <= '0;
            err_code   <= E_NONE;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            if (shift_bad) begin
              state    <= S_ERROR;
              err_code <= E_SHIFT;
            end else begin
              state     <= S_WRITE;
              mem_addr  <= addr_r;
              mem_wdata <= IW'({in_op, in_operand});
              last_r    <= in_last;
              // final word may sit at the top address without error
              ovf_r     <= at_top && !in_last;
            end
          end
        end
        S_WRITE: begin
          addr_r     <= addr_r + AW'(1);
          word_count <= word_count + (AW+1)'(1);
          if (last_r) begin
            state <= S_DONE;
          end else if (ovf_r) begin
            state    <= S_ERROR;
            err_code <= E_OVF;
          end else begin
            state <= S_ACCEPT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed scenarios plus randomized programs
// compared against a program-level model of what memory should receive.
module tb_instr_encoder;
  localparam int AW = 10;
  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [4:0]    in_operand = '0;
  logic          in_last = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_wdata;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic [AW:0]   word_count;

  int total = 0;
  int bad = 0;

  typedef struct { logic [AW-1:0] a; logic [IW-1:0] d; } wr_t;
  wr_t got[$];
  wr_t exp_q[$];

  logic [3:0] prog_op[16];
  logic [4:0] prog_opnd[16];
  logic       prog_last[16];

  logic       exp_done, exp_err;
  logic [1:0] exp_code;
  int         exp_cnt;

  instr_encoder #(.AW(AW), .IW(IW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_operand(in_operand), .in_last(in_last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // record every write strobe seen between edges
  always @(negedge clk) begin
    if (mem_we) got.push_back('{a: mem_addr, d: mem_wdata});
  end

  // program-level reference: what memory gets and how the load ends
  task automatic model(input int n, input logic [AW-1:0] base);
    int addr;
    exp_q.delete();
    exp_done = 0; exp_err = 0; exp_code = 2'b00; exp_cnt = 0;
    addr = base;
    for (int i = 0; i < n; i++) begin
      if ((prog_op[i] == 4'd13 || prog_op[i] == 4'd15) && prog_opnd[i] > 7) begin
        exp_err = 1; exp_code = 2'b01; return;
      end
      exp_q.push_back('{a: addr[AW-1:0], d: prog_op[i] * 32 + prog_opnd[i]});
      exp_cnt++;
      if (prog_last[i]) begin exp_done = 1; return; end
      if (addr == (1 << AW) - 1) begin exp_err = 1; exp_code = 2'b10; return; end
      addr++;
    end
  endtask

  task automatic run_prog(input string nm, input int n, input logic [AW-1:0] base,
                          input bit rnd_gap, input bit rnd_start);
    int idx, cyc;
    bit v;
    model(n, base);
    @(negedge clk);
    got.delete();
    start = 1; base_addr = base;
    @(negedge clk);
    start = 0;
    idx = 0; cyc = 0;
    while (!(done || err) && cyc < 300) begin
      v = (idx < n) && (!rnd_gap || ($urandom % 3 != 0));
      in_valid = v;
      if (idx < n) begin
        in_op = prog_op[idx]; in_operand = prog_opnd[idx]; in_last = prog_last[idx];
      end
      start = rnd_start && busy && ($urandom % 4 == 0);
      base_addr = AW'($urandom);
      if (v && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 0; start = 0; in_last = 0;
    total++;
    if (cyc >= 300) begin
      bad++; $display("FAIL %s timeout: cycles=%0d required<300", nm, cyc);
    end
    @(negedge clk);
    total++;
    if (got.size() != exp_q.size()) begin
      bad++; $display("FAIL %s write_count: got=%0d required=%0d", nm, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      total++;
      if (got[i].a !== exp_q[i].a || got[i].d !== exp_q[i].d) begin
        bad++; $display("FAIL %s write%0d: got=%h:%h required=%h:%h", nm, i,
                        got[i].a, got[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    total++;
    if (done !== exp_done || err !== exp_err || err_code !== exp_code) begin
      bad++; $display("FAIL %s status: done=%b err=%b code=%b required %b %b %b", nm,
                      done, err, err_code, exp_done, exp_err, exp_code);
    end
    total++;
    if (word_count !== (AW+1)'(exp_cnt)) begin
      bad++; $display("FAIL %s word_count: got=%0d required=%0d", nm, word_count, exp_cnt);
    end
  endtask

  task automatic set_beat(input int i, input logic [3:0] op, input logic [4:0] opnd, input logic last);
    prog_op[i] = op; prog_opnd[i] = opnd; prog_last[i] = last;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({in_ready, mem_we, busy, done, err} !== 5'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || word_count !== '0 || err_code !== 2'b00) begin
      bad++; $display("FAIL reset_values: rdy=%b we=%b busy=%b done=%b err=%b addr=%h data=%h cnt=%0d code=%b required all zero",
                      in_ready, mem_we, busy, done, err, mem_addr, mem_wdata, word_count, err_code);
    end
    @(negedge clk); reset_n = 1;
    // no start: valid beats must be ignored
    in_valid = 1; in_op = 4'd5; in_operand = 5'd1;
    got.delete();
    repeat (4) @(negedge clk);
    in_valid = 0;
    total++;
    if (got.size() != 0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL idle_ignore: writes=%0d rdy=%b required 0 0", got.size(), in_ready);
    end
  endtask

  task automatic test_basic;
    set_beat(0, 4'b0101, 5'b00011, 0);
    set_beat(1, 4'b1110, 5'b00101, 0);
    set_beat(2, 4'b0000, 5'b00010, 1);
    run_prog("basic", 3, 10'h010, 0, 0);
    total++;
    if (got.size() != 3 || got[0].a !== 10'h010 || got[0].d !== 9'h0A3 ||
        got[1].a !== 10'h011 || got[1].d !== 9'h1C5 || got[2].a !== 10'h012 || got[2].d !== 9'h002) begin
      bad++; $display("FAIL basic_words: size=%0d required 3 words 010=0A3 011=1C5 012=002", got.size());
    end
  endtask

  task automatic test_back_to_back;
    bit er, ew, ed;
    @(negedge clk); start = 1; base_addr = 10'h100;
    @(negedge clk); start = 0;
    for (int k = 0; k <= 6; k++) begin
      er = (k % 2 == 0) && k <= 4;
      ew = (k % 2 == 1) && k <= 5;
      ed = (k == 6);
      total++;
      if (in_ready !== er || mem_we !== ew || done !== ed) begin
        bad++; $display("FAIL b2b_cycle%0d: rdy=%b we=%b done=%b required %b %b %b",
                        k, in_ready, mem_we, done, er, ew, ed);
      end
      if (ew) begin
        total++;
        if (mem_addr !== AW'(10'h100 + k / 2)) begin
          bad++; $display("FAIL b2b_addr%0d: got=%h required=%h", k, mem_addr, 10'h100 + k / 2);
        end
      end
      in_valid = 1; in_op = 4'(k / 2 + 1); in_operand = 5'(k); in_last = (k / 2 == 2);
      @(negedge clk);
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic test_overflow;
    set_beat(0, 4'b0101, 5'b00001, 0);
    set_beat(1, 4'b0110, 5'b00010, 0);
    set_beat(2, 4'b0111, 5'b00011, 1);
    run_prog("overflow", 3, 10'h3FF, 0, 0);
    in_valid = 1;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || err !== 1'b1 || got.size() != 1) begin
      bad++; $display("FAIL ovf_hold: rdy=%b err=%b writes=%0d required 0 1 1", in_ready, err, got.size());
    end
    in_valid = 0;
    // final word at the top address completes cleanly
    set_beat(0, 4'b1001, 5'b00111, 0);
    set_beat(1, 4'b1000, 5'b01111, 1);
    run_prog("top_last", 2, 10'h3FE, 0, 0);
  endtask

  task automatic test_shift;
    set_beat(0, 4'b1101, 5'b01000, 0);
    set_beat(1, 4'b0101, 5'b00001, 1);
    run_prog("shift_bad", 2, 10'h020, 0, 0);
    set_beat(0, 4'b1111, 5'b00111, 0);
    set_beat(1, 4'b1101, 5'b00000, 1);
    run_prog("shift_ok_after_err", 2, 10'h040, 0, 0);
  endtask

  task automatic test_reset_in_write;
    @(negedge clk); start = 1; base_addr = 10'h200;
    @(negedge clk); start = 0;
    in_valid = 1; in_op = 4'd6; in_operand = 5'd9; in_last = 0;
    @(negedge clk);
    in_valid = 0;
    total++;
    if (mem_we !== 1'b1) begin
      bad++; $display("FAIL rst_write_setup: we=%b required 1", mem_we);
    end
    reset_n = 0;
    #1;
    total++;
    if ({in_ready, mem_we, busy, done, err} !== 5'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || word_count !== '0 || err_code !== 2'b00) begin
      bad++; $display("FAIL rst_in_write: rdy=%b we=%b busy=%b addr=%h data=%h cnt=%0d required all zero",
                      in_ready, mem_we, busy, mem_addr, mem_wdata, word_count);
    end
    @(negedge clk); reset_n = 1;
    got.delete();
    in_valid = 1;
    repeat (6) @(negedge clk);
    in_valid = 0;
    total++;
    if (got.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_no_resume: writes=%0d busy=%b required 0 0", got.size(), busy);
    end
  endtask

  task automatic test_random;
    int n;
    logic [AW-1:0] base;
    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        prog_op[i] = 4'($urandom_range(0, 15));
        prog_opnd[i] = 5'($urandom_range(0, 31));
        if ((prog_op[i] == 4'd13 || prog_op[i] == 4'd15) && $urandom % 4 != 0)
          prog_opnd[i] = 5'($urandom_range(0, 7));
        prog_last[i] = (i == n - 1);
      end
      base = ($urandom % 2 == 0) ? AW'($urandom) : AW'(10'h3FF - $urandom_range(0, 5));
      run_prog($sformatf("rand%0d", it), n, base, 1, 1);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_overflow;
    test_shift;
    test_reset_in_write;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
